// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg: shared definitions for the sequential 64-bit adder/subtractor.
//   - state_e        : FSM states (idle, running slices, result-valid pulse)
//   - DefWidth/Chunk : default operand width and slice width
//   - cnt_width()    : slice-counter width for a given number of slices
package seq_addsub_pkg;

    localparam int unsigned DefWidth = 64;
    localparam int unsigned DefChunk = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // A single-slice configuration still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefCntWidth = cnt_width(DefWidth / DefChunk);

endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple-carry slice.
//   a, b    : slice operands
//   cin     : carry into bit 0
//   s       : slice sum
//   cout    : carry out of the slice MSB
//   msb_cin : carry into the slice MSB (xor with cout gives signed overflow)
module rca_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             msb_cin
);

    always_comb begin
        logic [CHUNK:0] c;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout    = c[CHUNK];
        msb_cin = c[CHUNK-1];
    end

endmodule

// File: rtl/seq_addsub64.sv
// seq_addsub64: multi-cycle adder/subtractor resolving one CHUNK-bit slice per clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, sampled in idle or done
//   sub          : 0 = A+B+C_in, 1 = A-B-C_in (captured with start)
//   A, B, C_in   : operands and carry/borrow-in (captured with start)
//   busy         : high while slices are being resolved
//   done         : one-cycle pulse, result valid
//   sum          : result, held until the next accepted start
//   C_out        : carry-out (for sub, 1 = no borrow)
//   V            : two's-complement overflow
module seq_addsub64
    import seq_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CHUNK = DefChunk
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             C_out,
    output logic             V
);

    localparam int unsigned NumChunks = WIDTH / CHUNK;
    localparam int unsigned CntWidth  = cnt_width(NumChunks);
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumChunks - 1);

    state_e              state_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                carry_q;
    logic [CntWidth-1:0] cnt_q;
    logic [WIDTH-1:0]    sum_q;
    logic                c_out_q;
    logic                v_q;
    logic                busy_q;
    logic                done_q;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] s_slice;
    logic             slice_cout;
    logic             slice_msb_cin;

    always_comb begin
        a_slice = a_q[cnt_q*CHUNK +: CHUNK];
        b_slice = b_q[cnt_q*CHUNK +: CHUNK];
    end

    rca_chunk #(
        .CHUNK(CHUNK)
    ) u_rca_chunk (
        .a      (a_slice),
        .b      (b_slice),
        .cin    (carry_q),
        .s      (s_slice),
        .cout   (slice_cout),
        .msb_cin(slice_msb_cin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        // Subtraction as A + ~B + ~C_in: borrow-in maps to inverted carry-in.
                        a_q     <= A;
                        b_q     <= sub ? ~B : B;
                        carry_q <= sub ? ~C_in : C_in;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    sum_q[cnt_q*CHUNK +: CHUNK] <= s_slice;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CntWidth'(1);
                    if (cnt_q == LastCnt) begin
                        c_out_q <= slice_cout;
                        v_q     <= slice_cout ^ slice_msb_cin;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign C_out = c_out_q;
    assign V     = v_q;

endmodule
